fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
//
// PURPOSE
//   Instruction-fetch controller for the TPU ISA front end.
//   - Owns the program counter and sequences it: load on start/redirect, increment on fetch.
//   - Issues one-at-a-time requests to instruction memory and hands fetched words to decode
//     over a valid/ready handshake.
//   - Sits between the instruction memory port and the decoder; the execute stage drives redirects.
//
// PARAMETERS
//   CNT_WIDTH   8   PC / instruction-memory address width (words); PC wraps modulo 2**CNT_WIDTH
//   INST_WIDTH  16  instruction word width
//
// PORTS
//   clk             in   1           clock; all state updates on posedge
//   nrst            in   1           reset, synchronous, active-low
//   start           in   1           begin fetching at start_addr; honoured only in IDLE
//   start_addr      in   CNT_WIDTH   initial PC
//   halt            in   1           stop fetching (level or pulse; sampled each cycle)
//   br_valid        in   1           redirect from execute, single-cycle pulse
//   br_target       in   CNT_WIDTH   redirect PC
//   imem_req_valid  out  1           fetch request
//   imem_req_ready  in   1           memory accepts request this cycle
//   imem_req_addr   out  CNT_WIDTH   fetch address (= PC)
//   imem_rsp_valid  in   1           read data valid (>=1 cycle after accept; in order)
//   imem_rsp_data   in   INST_WIDTH  read data
//   inst_valid      out  1           instruction available to decode
//   inst_ready      in   1           decode accepts instruction
//   inst_data       out  INST_WIDTH  instruction word
//   inst_pc         out  CNT_WIDTH   address the instruction came from
//   busy            out  1           high in any state other than IDLE
//
// BEHAVIOUR
//   - All outputs are registered or decoded from state/registers.
//   - Reset (nrst=0 at posedge): state=IDLE, pc=0, inst_data=0, inst_pc=0.
//     imem_req_valid=0, inst_valid=0, busy=0. Reset mid-request drops the request silently.
//   - States:
//     IDLE   start=1 -> pc<=start_addr, REQ.
//     REQ    imem_req_valid=1, imem_req_addr=pc. On imem_req_ready: capture fetch_pc<=pc, go WAIT.
//     WAIT   on imem_rsp_valid: inst_data<=rsp_data, inst_pc<=fetch_pc, pc<=pc+1 (wraps to 0), go HOLD.
//     HOLD   inst_valid=1; data and pc are stable until accepted.
//            On inst_ready: go REQ, or IDLE if halt_pend is set.
//     DRAIN  request outstanding but stale. Discard the next imem_rsp_valid, then go REQ (IDLE if halt_pend).
//   - Throughput: at most 1 instruction per 3 cycles (REQ, WAIT, HOLD) with zero-wait memory.
//     One outstanding memory request maximum.
//   - Redirect (br_valid=1, any state except IDLE); pc<=br_target next cycle:
//     REQ without ready       -> stay REQ. The address may change before acceptance (permitted by imem protocol).
//     REQ with ready, or WAIT -> DRAIN. A rsp_valid in the same WAIT cycle is discarded and DRAIN is skipped (go REQ).
//     HOLD                    -> inst_valid deasserts next cycle, go REQ. If inst_ready was also high,
//                                the word counts as accepted; the redirect still wins for PC.
//     DRAIN                   -> stay DRAIN; pc updated.
//     br_valid in IDLE is ignored.
//   - Halt:
//     - halt=1 sets halt_pend. halt_pend clears on entry to IDLE.
//     - In REQ with no acceptance this cycle -> IDLE immediately.
//     - WAIT completes into HOLD.
//     - HOLD goes to IDLE after acceptance.
//     - DRAIN goes to IDLE after the discard.
//     - The PC is retained in IDLE. A subsequent start overrides it.
//   - Priority when simultaneous: nrst > br_valid > halt > start. start while busy is ignored.
//   - Wrap: pc = 2**CNT_WIDTH-1 increments to 0; no flag is raised.
//
// STRUCTURE
//   - Package tpu_isa_pkg:
//     - typedef enum logic [2:0] fetch_state_e {IDLE, REQ, WAIT, HOLD, DRAIN}.
//     - Default width constants (PC_W=8, INST_W=16).
//   - PC register and FSM live in this module; no sub-module is required.
//   - An optional 1-entry output skid buffer (fetch_skid_buf) is the natural split if throughput is
//     later raised to 1/cycle.
//
// TESTING
//   - Reset/start: nrst low 2 cycles, start=1 start_addr=0x10, zero-wait memory returning addr^0xA5A5.
//     -> Reset check: busy=0, inst_valid=0.
//     -> Fetch check: imem_req_addr 0x10,0x11,0x12; inst_pc/inst_data pairs match; one instruction per 3 cycles.
//   - Backpressure: inst_ready=0 for 5 cycles in HOLD -> inst_valid held, inst_data/inst_pc stable,
//     no new imem request issued.
//   - Redirect during WAIT: 3-cycle memory latency, br_target=0x40 one cycle after accept
//     -> stale response discarded (never on inst_valid); next imem_req_addr=0x40.
//   - Redirect in HOLD with inst_ready=1 same cycle -> word accepted once; next request addr=br_target.
//   - Halt and wrap: start_addr=0xFE, halt after 3 accepts -> addrs 0xFE,0xFF,0x00.
//     -> State returns to IDLE; busy=0; br_valid in IDLE produces no request.
//   - Reset mid-WAIT: nrst=0 while a response is pending -> late imem_rsp_valid ignored; all outputs at reset values.

Source files
------------

// File: rtl/tpu_isa_pkg.sv
// Shared types and default widths for the TPU ISA front end.
package tpu_isa_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } fetch_state_e;

    localparam int PC_W   = 8;
    localparam int INST_W = 16;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one imem request at a time
// and presents each fetched word to decode over valid/ready.
module fetch_sequencer
    import tpu_isa_pkg::*;
#(
    parameter int CNT_WIDTH  = PC_W,
    parameter int INST_WIDTH = INST_W
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  start_addr,
    input  logic                  halt,
    input  logic                  br_valid,
    input  logic [CNT_WIDTH-1:0]  br_target,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [CNT_WIDTH-1:0]  imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst_data,
    output logic [CNT_WIDTH-1:0]  inst_pc,
    output logic                  busy
);

    fetch_state_e          state_q, state_d;
    logic [CNT_WIDTH-1:0]  pc_q, pc_d;
    logic [CNT_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
    logic [CNT_WIDTH-1:0]  inst_pc_q, inst_pc_d;
    logic [INST_WIDTH-1:0] inst_data_q, inst_data_d;
    logic                  halt_pend_q, halt_pend_d;
    logic                  halt_eff;

    // A halt raised this cycle acts immediately, not only once latched.
    assign halt_eff = halt | halt_pend_q;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && !halt) state_d = REQ;
            end
            REQ: begin
                if (imem_req_ready)  state_d = br_valid ? DRAIN : WAIT;
                else if (br_valid)   state_d = REQ;
                else if (halt_eff)   state_d = IDLE;
            end
            WAIT: begin
                // A response landing with the redirect is dropped on the spot,
                // so nothing remains to drain.
                if (br_valid)            state_d = imem_rsp_valid ? REQ : DRAIN;
                else if (imem_rsp_valid) state_d = HOLD;
            end
            HOLD: begin
                if (br_valid)        state_d = REQ;
                else if (inst_ready) state_d = halt_eff ? IDLE : REQ;
            end
            DRAIN: begin
                if (imem_rsp_valid)  state_d = (halt_eff && !br_valid) ? IDLE : REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid = (state_q == REQ);
        imem_req_addr  = pc_q;
        inst_valid     = (state_q == HOLD);
        inst_data      = inst_data_q;
        inst_pc        = inst_pc_q;
        busy           = (state_q != IDLE);
    end

    always_comb begin
        pc_d        = pc_q;
        fetch_pc_d  = fetch_pc_q;
        inst_pc_d   = inst_pc_q;
        inst_data_d = inst_data_q;
        case (state_q)
            IDLE: begin
                if (start && !halt) pc_d = start_addr;
            end
            REQ: begin
                if (imem_req_ready) fetch_pc_d = pc_q;
            end
            WAIT: begin
                if (imem_rsp_valid && !br_valid) begin
                    inst_data_d = imem_rsp_data;
                    inst_pc_d   = fetch_pc_q;
                    pc_d        = pc_q + CNT_WIDTH'(1);
                end
            end
            default: ;
        endcase
        // Redirect wins over increment and start for the PC.
        if ((state_q != IDLE) && br_valid) pc_d = br_target;
        if (state_d == IDLE) halt_pend_d = 1'b0;
        else                 halt_pend_d = halt_pend_q | halt;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            pc_q        <= '0;
            fetch_pc_q  <= '0;
            inst_pc_q   <= '0;
            inst_data_q <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            fetch_pc_q  <= fetch_pc_d;
            inst_pc_q   <= inst_pc_d;
            inst_data_q <= inst_data_d;
            halt_pend_q <= halt_pend_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized run, scored
// against a transaction-level model of program order and memory contents.
module tb_fetch_sequencer;
    import tpu_isa_pkg::*;

    localparam int CW = 8;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          nrst, start, halt, br_valid, inst_ready;
    logic          imem_req_ready = 1'b0;
    logic          imem_rsp_valid = 1'b0;
    logic [CW-1:0] start_addr, br_target, imem_req_addr, inst_pc;
    logic [IW-1:0] imem_rsp_data = '0;
    logic [IW-1:0] inst_data;
    logic          imem_req_valid, inst_valid, busy;

    fetch_sequencer #(.CNT_WIDTH(CW), .INST_WIDTH(IW)) dut (
        .clk(clk), .nrst(nrst), .start(start), .start_addr(start_addr),
        .halt(halt), .br_valid(br_valid), .br_target(br_target),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Memory model and program-order scoreboard state.
    int          rdy_pct  = 100;
    int          lat_min  = 1;
    int          lat_max  = 1;
    bit          mem_pend = 1'b0;
    int          mem_cnt  = 0;
    logic [CW-1:0] mem_addr = '0;
    logic [CW-1:0] exp_pc   = '0;
    longint      cyc      = 0;
    logic [CW-1:0] req_log[$];
    logic [CW-1:0] acc_pc[$];
    longint      acc_cyc[$];

    function automatic logic [IW-1:0] mem_word(input logic [CW-1:0] a);
        return {{(IW-CW){1'b0}}, a} ^ 16'hA5A5;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Runs at every falling edge: answers imem in order, scores every handoff.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            imem_rsp_valid = 1'b0;
            if (mem_pend) begin
                if (mem_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(mem_addr);
                    mem_pend       = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end
            imem_req_ready = ($urandom_range(99) < rdy_pct);
            if (nrst && imem_req_valid && imem_req_ready) begin
                check("one_outstanding", 32'(mem_pend), 0);
                mem_pend = 1'b1;
                mem_addr = imem_req_addr;
                mem_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
                req_log.push_back(imem_req_addr);
            end
            if (!nrst) begin
                exp_pc = '0;
            end else begin
                if (inst_valid && inst_ready) begin
                    check("inst_pc", 32'(inst_pc), 32'(exp_pc));
                    check("inst_data", 32'(inst_data), 32'(mem_word(exp_pc)));
                    acc_pc.push_back(inst_pc);
                    acc_cyc.push_back(cyc);
                    exp_pc = exp_pc + 8'd1;
                end
                if (br_valid && busy)                exp_pc = br_target;
                else if (start && !busy && !halt)    exp_pc = start_addr;
            end
        end
    end

    initial begin
        int n, a;
        logic [CW-1:0] p;
        logic [IW-1:0] d;

        nrst = 1'b0; start = 1'b0; halt = 1'b0; br_valid = 1'b0;
        br_target = '0; start_addr = '0; inst_ready = 1'b1;
        tick(2);
        check("rst_busy", 32'(busy), 0);
        check("rst_inst_valid", 32'(inst_valid), 0);
        check("rst_req_valid", 32'(imem_req_valid), 0);
        check("rst_inst_pc", 32'(inst_pc), 0);
        check("rst_inst_data", 32'(inst_data), 0);

        // Start at 0x10 with zero-wait memory.
        nrst = 1'b1; start_addr = 8'h10; start = 1'b1;
        tick(1);
        start = 1'b0;
        check("start_busy", 32'(busy), 1);
        for (int k = 0; k < 60 && acc_pc.size() < 3; k++) tick(1);
        check("fetch_count", 32'(acc_pc.size() >= 3), 1);
        check("req_addr0", 32'(req_log[0]), 32'h10);
        check("req_addr1", 32'(req_log[1]), 32'h11);
        check("req_addr2", 32'(req_log[2]), 32'h12);
        check("acc_pc0", 32'(acc_pc[0]), 32'h10);
        check("acc_pc2", 32'(acc_pc[2]), 32'h12);
        check("tput01", 32'(acc_cyc[1] - acc_cyc[0]), 3);
        check("tput12", 32'(acc_cyc[2] - acc_cyc[1]), 3);

        // Backpressure in HOLD.
        inst_ready = 1'b0;
        for (int k = 0; k < 20 && !inst_valid; k++) tick(1);
        check("bp_valid", 32'(inst_valid), 1);
        p = inst_pc; d = inst_data; n = req_log.size();
        for (int k = 0; k < 5; k++) begin
            tick(1);
            check("bp_hold_valid", 32'(inst_valid), 1);
            check("bp_hold_pc", 32'(inst_pc), 32'(p));
            check("bp_hold_data", 32'(inst_data), 32'(d));
            check("bp_no_req", 32'(imem_req_valid), 0);
        end
        check("bp_req_count", 32'(req_log.size()), 32'(n));
        inst_ready = 1'b1;

        // Redirect one cycle after a 3-cycle-latency request is accepted.
        lat_min = 3; lat_max = 3;
        for (int k = 0; k < 20 && !imem_req_valid; k++) tick(1);
        check("rw_req_seen", 32'(imem_req_valid), 1);
        tick(1);
        check("rw_in_wait", 32'(busy && !imem_req_valid && !inst_valid), 1);
        n = req_log.size(); a = acc_pc.size();
        br_valid = 1'b1; br_target = 8'h40;
        tick(1);
        br_valid = 1'b0;
        for (int k = 0; k < 20 && req_log.size() <= n; k++) tick(1);
        check("rw_next_req", 32'(req_log[n]), 32'h40);
        for (int k = 0; k < 30 && acc_pc.size() <= a; k++) tick(1);
        check("rw_next_inst", 32'(acc_pc[a]), 32'h40);

        // Redirect in HOLD together with inst_ready.
        lat_min = 1; lat_max = 1;
        inst_ready = 1'b0;
        for (int k = 0; k < 20 && !inst_valid; k++) tick(1);
        a = acc_pc.size(); n = req_log.size(); p = inst_pc;
        inst_ready = 1'b1; br_valid = 1'b1; br_target = 8'h80;
        tick(1);
        br_valid = 1'b0;
        check("rh_accepted_once", 32'(acc_pc.size()), 32'(a + 1));
        check("rh_accepted_pc", 32'(acc_pc[a]), 32'(p));
        check("rh_valid_drop", 32'(inst_valid), 0);
        check("rh_req_addr", 32'(imem_req_addr), 32'h80);
        for (int k = 0; k < 20 && req_log.size() <= n; k++) tick(1);
        check("rh_next_req", 32'(req_log[n]), 32'h80);
        for (int k = 0; k < 20 && acc_pc.size() <= a + 1; k++) tick(1);
        check("rh_next_inst", 32'(acc_pc[a + 1]), 32'h80);

        // Halt to IDLE, then wrap across 0xFF and halt after the third accept.
        halt = 1'b1;
        tick(1);
        halt = 1'b0;
        for (int k = 0; k < 20 && busy; k++) tick(1);
        check("halt_idle", 32'(busy), 0);
        n = req_log.size(); a = acc_pc.size();
        start_addr = 8'hFE; start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int k = 0; k < 30 && !(inst_valid && acc_pc.size() == a + 2); k++) tick(1);
        halt = 1'b1;
        tick(1);
        halt = 1'b0;
        check("wrap_acc_count", 32'(acc_pc.size()), 32'(a + 3));
        check("wrap_acc0", 32'(acc_pc[a]), 32'hFE);
        check("wrap_acc1", 32'(acc_pc[a + 1]), 32'hFF);
        check("wrap_acc2", 32'(acc_pc[a + 2]), 32'h00);
        check("wrap_req0", 32'(req_log[n]), 32'hFE);
        check("wrap_req1", 32'(req_log[n + 1]), 32'hFF);
        check("wrap_req2", 32'(req_log[n + 2]), 32'h00);
        check("wrap_idle", 32'(busy), 0);
        br_valid = 1'b1; br_target = 8'h33;
        tick(1);
        br_valid = 1'b0;
        tick(3);
        check("idle_br_no_req", 32'(imem_req_valid), 0);
        check("idle_br_busy", 32'(busy), 0);
        check("idle_br_req_count", 32'(req_log.size()), 32'(n + 3));
        check("pc_retained", 32'(imem_req_addr), 32'h01);

        // Reset while a 3-cycle response is pending.
        lat_min = 3; lat_max = 3;
        start_addr = 8'h20; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        check("rm_req_addr", 32'(req_log[$]), 32'h20);
        nrst = 1'b0;
        tick(1);
        nrst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("rm_busy", 32'(busy), 0);
            check("rm_inst_valid", 32'(inst_valid), 0);
            check("rm_req_valid", 32'(imem_req_valid), 0);
            tick(1);
        end
        check("rm_inst_pc", 32'(inst_pc), 0);
        check("rm_inst_data", 32'(inst_data), 0);
        check("rm_req_addr_rst", 32'(imem_req_addr), 0);

        // Randomized run: stalls, variable latency, random redirects.
        rdy_pct = 60; lat_min = 1; lat_max = 4;
        start_addr = CW'($urandom); start = 1'b1;
        tick(1);
        start = 1'b0;
        a = acc_pc.size();
        for (int k = 0; k < 400; k++) begin
            inst_ready = ($urandom_range(9) < 7);
            br_valid   = busy && ($urandom_range(15) == 0);
            br_target  = CW'($urandom);
            tick(1);
        end
        br_valid = 1'b0; inst_ready = 1'b1;
        check("rand_progress", 32'(acc_pc.size() - a > 20), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
